// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Owns the fetch PC, issues word
//                requests to instruction memory under a credit limit, queues
//                the returned words with their PCs, and hands them to decode
//                over a valid/ready handshake. Every redirect squashes the
//                queue and discards responses that are still in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC  fetch address after reset
//    DEPTH     queue entries; also the limit on outstanding requests plus
//              queued words (>= 1)
//  Ports
//    clk, rst                          clock, async active-high reset
//    PCSrc, ex_valid, ex_pc,
//    ImmExt, ALUResult                 redirect request from execute
//    imem_req_valid/ready, imem_addr   request channel to instruction memory
//    imem_rsp_valid, imem_rdata        in-order response channel
//    instr_valid/ready, Instr,
//    pc_out, pc_plus4                  instruction channel to decode
//    misalign_o                        misaligned redirect target flag
//  Configuration
//    FETCH_MISALIGN_TRAP_EN  when defined, a misaligned redirect target halts
//                            fetch and raises misalign_o until an aligned
//                            redirect arrives; otherwise target[1:0] is
//                            forced to 00 and misalign_o stays 0.
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misalign_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   c_LIMIT    = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] c_LAST_IDX = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;      // PC owed to the next kept response
    logic [CW-1:0] r_out;         // requests accepted, response not yet seen
    logic [CW-1:0] r_cnt;         // words held in the queue
    logic [CW-1:0] r_drop;        // wrong-path responses still to discard
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic          r_misalign;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];

    logic        w_redirect;
    logic [31:0] w_raw_target;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_credit;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_rsp_accept;
    logic        w_nonempty;
    logic        w_instr_valid;
    logic        w_push;
    logic        w_pop;
    logic        w_unused;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect   = ex_valid & ((PCSrc == 2'b01) | (PCSrc == 2'b10));
    assign w_raw_target = (PCSrc == 2'b01) ? (ex_pc + ImmExt)
                                           : {ALUResult[31:1], 1'b0};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target     = w_raw_target;
    assign w_misaligned = (w_raw_target[1:0] != 2'b00);
`else
    assign w_target     = {w_raw_target[31:2], 2'b00};
    assign w_misaligned = 1'b0;
`endif

    assign w_unused = ^{ALUResult[0], w_raw_target[1:0]};

    // Words in flight plus words queued may never exceed the queue size, so a
    // response always finds a free slot even if decode stalls indefinitely.
    assign w_credit      = ({1'b0, r_out} + {1'b0, r_cnt}) < c_LIMIT;
    assign w_req_valid   = (r_state == S_RUN) & w_credit & ~w_redirect;
    assign w_req_fire    = w_req_valid & imem_req_ready;
    // A response with nothing outstanding is spurious and ignored entirely.
    assign w_rsp_accept  = imem_rsp_valid & (r_out != '0);
    assign w_nonempty    = (r_cnt != '0);
    assign w_instr_valid = w_nonempty & ~w_redirect & (r_state != S_HALT);
    assign w_pop         = w_instr_valid & instr_ready;
    assign w_push        = w_rsp_accept & (r_drop == '0) & ~w_redirect
                         & (r_state != S_HALT);

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_fetch_pc;
    assign instr_valid    = w_instr_valid;
    assign Instr          = w_nonempty ? r_q_instr[r_rd] : 32'd0;
    assign pc_out         = w_nonempty ? r_q_pc[r_rd] : 32'd0;
    assign pc_plus4       = w_nonempty ? (r_q_pc[r_rd] + 32'd4) : 32'd0;
    assign misalign_o     = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out      <= '0;
            r_cnt      <= '0;
            r_drop     <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_RUN;
                default: ;
            endcase

            case ({w_req_fire, w_rsp_accept})
                2'b10:   r_out <= r_out + CW'(1);
                2'b01:   r_out <= r_out - CW'(1);
                default: ;
            endcase

            if (w_redirect) begin
                // Everything still owed by memory belongs to the old path,
                // except a response being consumed this very cycle.
                r_drop     <= r_out - (w_rsp_accept ? CW'(1) : CW'(0));
                r_cnt      <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_misalign <= w_misaligned;
                if (w_misaligned) begin
                    r_state <= S_HALT;
                end else if (r_state == S_HALT) begin
                    r_state <= S_RUN;
                end
            end else begin
                if (w_rsp_accept && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wr     <= f_next(r_wr);
                end
                if (w_pop) begin
                    r_rd <= f_next(r_rd);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Queue storage carries no reset: outputs are masked while it is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr] <= imem_rdata;
            r_q_pc[r_wr]    <= r_rsp_pc;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the PCSrc redirect encoding produced by the control decoder and owns the architectural fetch PC.
- Issues word requests to instruction memory through a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small queue and presents Instr/PC to the decode stage over a valid/ready handshake.
- Squashes wrong-path words on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, instruction queue entries; also the credit limit for outstanding requests plus queued words (≥1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PCSrc  in  2  00 PC+4 (no redirect), 01 PC+imm (branch/jal), 10 ALUResult (jalr), 11 reserved = 00
- ex_valid  in  1  qualifies PCSrc/ex_pc/ImmExt/ALUResult this cycle
- ex_pc  in  32  PC of the resolving instruction
- ImmExt  in  32  sign-extended immediate
- ALUResult  in  32  jalr target source
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  word address of request, bits[1:0]=00
- imem_rsp_valid  in  1  response valid (in order, no backpressure)
- imem_rdata  in  32  response word
- instr_valid  out  1  Instr/pc_out valid to decode
- instr_ready  in  1  decode accepts
- Instr  out  32  instruction word
- pc_out  out  32  PC of Instr
- pc_plus4  out  32  pc_out + 4 (mod 2^32)
- misalign_o  out  1  misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0. All outputs 0 except imem_addr=RESET_PC.
- States:
  - IDLE: one cycle after reset release, no request, then RUN.
  - RUN: normal fetch.
  - HALT: only with the macro; left only by reset or a valid redirect.
- Redirect = ex_valid & (PCSrc==01 | PCSrc==10).
  - Target for 01: ex_pc+ImmExt, 32-bit wrap.
  - Target for 10: {ALUResult[31:1],1'b0}.
- Request issue, RUN only: imem_req_valid = (outstanding + count < DEPTH) & ~redirect.
  - imem_addr = fetch_pc.
  - On req handshake: fetch_pc += 4 (wraps 0xFFFF_FFFC→0), outstanding++.
  - imem_req_valid, once high, holds with a stable address until ready, unless a redirect occurs.
- Responses: each imem_rsp_valid decrements outstanding.
  - drop>0: word discarded, drop--.
  - drop==0: word pushed to queue with its PC, tracked by a response-PC counter.
  - imem_rsp_valid with outstanding==0: ignored.
- Decode side: instr_valid = queue non-empty & ~redirect. Pop on instr_valid & instr_ready. Instr/pc_out/pc_plus4 come from the queue head and are stable while valid & ~ready.
- Redirect cycle:
  - Queue cleared; push/pop suppressed; no request issued.
  - drop <= outstanding − (imem_rsp_valid ? 1 : 0).
  - fetch_pc and response-PC counter <= target (bits[1:0] handled per Optional Feature).
  - A pending unaccepted request is withdrawn.
  - Requests resume the next cycle, so the first possible new-path request address is target at cycle+1.
- Simultaneous push and pop with a full queue: allowed, count unchanged.
- Queue full never overflows, guaranteed by the credit rule.
- Redirect arriving in IDLE takes effect; IDLE then still proceeds to RUN.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Redirect with target[1:0]≠00: enter HALT; misalign_o=1 held; no requests; instr_valid=0; in-flight responses dropped.
  - A later aligned redirect returns to RUN, clears misalign_o, and fetches from its target.
  - A misaligned redirect while in HALT stays in HALT.
- Undefined: target[1:0] forced to 00; misalign_o tied 0; HALT unreachable.

Test Plan:
- Reset/sequential: rst pulse, 1-cycle-latency memory, instr_ready=1 → imem_addr 0x0,0x4,0x8…; pc_out 0x0,0x4,0x8 with matching rdata; pc_plus4 = pc_out+4.
- Backpressure: instr_ready=0 for 6 cycles, DEPTH=2, imem_req_ready=1 → at most 2 requests issued, then imem_req_valid=0. On release, words 0x0,0x4 then 0x8 are delivered with no loss or duplication.
- Branch with flush: 2 responses in flight, ex_valid=1, PCSrc=01, ex_pc=0x10, ImmExt=0x20 → next request 0x30. Both stale responses discarded. First instr_valid word has pc_out=0x30.
- JALR: PCSrc=10, ALUResult=0x45 → next request 0x44. PCSrc=11 with ex_valid=1 → no redirect, sequential fetch continues.
- Misaligned (FETCH_MISALIGN_TRAP_EN defined): PCSrc=01, ex_pc=0x10, ImmExt=0x22 → misalign_o=1, no requests. Then PCSrc=10, ALUResult=0x40 → misalign_o=0, fetch from 0x40. Macro undefined: same first stimulus fetches 0x30.
- Async reset mid-operation: assert rst while the queue is full and 1 request is outstanding → outputs 0 immediately. After release, fetch restarts at RESET_PC and the old response is ignored.
